// File: rtl/xorshift_pkg.sv
// xorshift_pkg: shared constants, phase/state encodings and lane seeding for the xorshift stimulus generator
package xorshift_pkg;

    localparam logic [31:0] XS_X0        = 32'd123456789;
    localparam logic [31:0] XS_Y0        = 32'd362436069;
    localparam logic [31:0] XS_Z0        = 32'd521288629;
    localparam logic [31:0] XS_LANE_SALT = 32'h9E3779B9;

    typedef enum logic [1:0] {
        PH_ZERO = 2'd0,
        PH_ONES = 2'd1,
        PH_RAND = 2'd2
    } xsPhase;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZERO,
        ST_ONES,
        ST_RAND,
        ST_DONE
    } xsState;

    // Lane 0 keeps the raw seed so it reproduces the legacy single-lane sequence
    function automatic logic [31:0] laneSeed(input logic [31:0] seed, input int lane);
        return seed ^ (32'(lane) * XS_LANE_SALT);
    endfunction

endpackage

// File: rtl/xorshift128_core.sv
// xorshift128_core: one xorshift128 generator lane with reseed and single-step controls
module xorshift128_core
    import xorshift_pkg::*;
#(
    parameter logic [31:0] INIT_W = 32'd1652613690
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         step,
    input  logic [31:0]  loadW,
    output logic [127:0] state
);

    logic [31:0] x, y, z, w, t;

    assign t     = x ^ (x << 11);
    assign state = {x, y, z, w};

    // Generator words: reseed on load, otherwise advance one step when asked
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {x, y, z, w} <= {XS_X0, XS_Y0, XS_Z0, INIT_W};
        end else if (load) begin
            {x, y, z, w} <= {XS_X0, XS_Y0, XS_Z0, loadW};
        end else if (step) begin
            x <= y;
            y <= z;
            z <= w;
            w <= w ^ (w >> 19) ^ t ^ (t >> 8);
        end
    end

endmodule

// File: rtl/xorshift_stim_gen.sv
// xorshift_stim_gen: zero/ones/random stimulus beats over valid/ready; XORSHIFT_STIM_SEED_LOAD_EN enables runtime reseed
module xorshift_stim_gen
    import xorshift_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter int          CHANNELS = 1,
    parameter int          COUNT    = 1000,
    parameter logic [31:0] SEED     = 32'd1652613690
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      seed_load,
    input  logic [31:0]               seed_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [1:0]                out_phase,
    output logic [31:0]               out_index,
    output logic                      busy,
    output logic                      done
);

    localparam logic [31:0] LAST_INDEX = 32'(COUNT - 1);

    xsState state;
    xsPhase phase;
    logic accept, idleLike, stepGen, loadGen;
    logic [CHANNELS*WIDTH-1:0] laneData;

    assign accept    = out_valid & out_ready;
    assign idleLike  = (state == ST_IDLE) | (state == ST_DONE);
    assign stepGen   = accept & ((state == ST_ONES) | ((state == ST_RAND) & (out_index != LAST_INDEX)));
    assign out_phase = phase;

`ifdef XORSHIFT_STIM_SEED_LOAD_EN
    assign loadGen = seed_load & idleLike;
`else
    logic unusedSeedLoad;
    assign unusedSeedLoad = seed_load;
    assign loadGen = 1'b0;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : gLane
        logic [127:0] laneState;
        logic unusedLaneBits;
        xorshift128_core #(.INIT_W(laneSeed(SEED, c))) core (
            .clock  (clock),
            .reset_n(reset_n),
            .load   (loadGen),
            .step   (stepGen),
            .loadW  (laneSeed(seed_in, c)),
            .state  (laneState)
        );
        assign laneData[c*WIDTH +: WIDTH] = laneState[WIDTH-1:0];
        assign unusedLaneBits = ^laneState;
    end

    // Sequence control: walks zero, ones, then COUNT random beats, advancing only on accept
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            phase     <= PH_ZERO;
            out_valid <= 1'b0;
            out_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_ZERO;
                        phase     <= PH_ZERO;
                        out_valid <= 1'b1;
                        out_index <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                ST_ZERO: begin
                    if (accept) begin
                        state <= ST_ONES;
                        phase <= PH_ONES;
                    end
                end
                ST_ONES: begin
                    if (accept) begin
                        state     <= ST_RAND;
                        phase     <= PH_RAND;
                        out_index <= '0;
                    end
                end
                ST_RAND: begin
                    if (accept && out_index == LAST_INDEX) begin
                        state     <= ST_DONE;
                        phase     <= PH_ZERO;
                        out_valid <= 1'b0;
                        out_index <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (accept) begin
                        out_index <= out_index + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Payload follows the state: fixed patterns for the first two beats, generator words after
    always_comb begin
        out_data = (state == ST_ZERO) ? '0 : (state == ST_ONES) ? '1 : (state == ST_RAND) ? laneData : '0;
    end

endmodule

// File: tb/tb_xorshift_stim_gen.sv
// tb_xorshift_stim_gen: randomized handshake bench against a recurrence-sequence model of xorshift128
module tb_xorshift_stim_gen;

    localparam logic [31:0] SEED = 32'd1652613690;
    localparam int A_COUNT = 1000;
    localparam int B_CH    = 3;
    localparam int B_W     = 8;
    localparam int B_COUNT = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic aStart = 1'b0, aLoad = 1'b0, aReady = 1'b0;
    logic [31:0] aSeed = '0;
    logic aValid, aBusy, aDone;
    logic [3:0] aData;
    logic [1:0] aPhase;
    logic [31:0] aIndex;

    logic bStart = 1'b0, bLoad = 1'b0, bReady = 1'b0;
    logic [31:0] bSeed = '0;
    logic bValid, bBusy, bDone;
    logic [23:0] bData;
    logic [1:0] bPhase;
    logic [31:0] bIndex;

    xorshift_stim_gen dutA (
        .clock(clock), .reset_n(reset_n), .start(aStart), .seed_load(aLoad), .seed_in(aSeed),
        .out_valid(aValid), .out_ready(aReady), .out_data(aData), .out_phase(aPhase),
        .out_index(aIndex), .busy(aBusy), .done(aDone)
    );

    xorshift_stim_gen #(.WIDTH(B_W), .CHANNELS(B_CH), .COUNT(B_COUNT)) dutB (
        .clock(clock), .reset_n(reset_n), .start(bStart), .seed_load(bLoad), .seed_in(bSeed),
        .out_valid(bValid), .out_ready(bReady), .out_data(bData), .out_phase(bPhase),
        .out_index(bIndex), .busy(bBusy), .done(bDone)
    );

    int passed = 0;
    int total = 0;
    int holdBad = 0;
    int steps = 0;

    // hist[3*n + c] is word n of lane c's sequence s: s[0..3] = x,y,z,w and w after j steps is s[3+j]
    logic [31:0] hist [$];
    logic [23:0] expData [$];
    logic [1:0]  expPhase [$];
    logic [31:0] expIndex [$];
    logic [23:0] obsData [$];
    logic [1:0]  obsPhase [$];
    logic [31:0] obsIndex [$];

    task automatic modelSeed(input logic [31:0] s);
        hist.delete();
        for (int c = 0; c < 3; c++) hist.push_back(32'd123456789);
        for (int c = 0; c < 3; c++) hist.push_back(32'd362436069);
        for (int c = 0; c < 3; c++) hist.push_back(32'd521288629);
        for (int c = 0; c < 3; c++) hist.push_back(s ^ (32'(c) * 32'h9E3779B9));
        steps = 0;
    endtask

    task automatic word(input int c, input int n, output logic [31:0] v);
        int k;
        logic [31:0] a, b, t;
        while (hist.size() < 3 * (n + 1)) begin
            k = hist.size() / 3;
            for (int l = 0; l < 3; l++) begin
                a = hist[3 * (k - 4) + l];
                b = hist[3 * (k - 1) + l];
                t = a ^ (a << 11);
                hist.push_back(b ^ (b >> 19) ^ t ^ (t >> 8));
            end
        end
        v = hist[3 * n + c];
    endtask

    task automatic buildExp(input int lanes, input int width, input int count);
        logic [23:0] d, m;
        logic [31:0] v;
        expData.delete(); expPhase.delete(); expIndex.delete();
        m = '0;
        for (int b = 0; b < lanes * width; b++) m[b] = 1'b1;
        expData.push_back('0); expPhase.push_back(2'd0); expIndex.push_back(32'd0);
        expData.push_back(m);  expPhase.push_back(2'd1); expIndex.push_back(32'd0);
        for (int k = 0; k < count; k++) begin
            steps++;
            d = '0;
            for (int c = 0; c < lanes; c++) begin
                word(c, steps + 3, v);
                for (int b = 0; b < width; b++) d[c * width + b] = v[b];
            end
            expData.push_back(d); expPhase.push_back(2'd2); expIndex.push_back(32'(k));
        end
    endtask

    task automatic clearObs();
        obsData.delete(); obsPhase.delete(); obsIndex.delete();
        holdBad = 0;
    endtask

    task automatic collectA(input int n, input int readyPct);
        int cyc = 0;
        logic pv = 1'b0, pa = 1'b0;
        logic [3:0] pd = '0;
        logic [1:0] pp = '0;
        logic [31:0] pi = '0;
        while (obsData.size() < n && cyc < 40 * n + 100) begin
            if (pv && !pa && (!aValid || aData !== pd || aPhase !== pp || aIndex !== pi)) holdBad++;
            aReady = ($urandom_range(99, 0) < readyPct);
            pv = aValid; pa = aValid & aReady; pd = aData; pp = aPhase; pi = aIndex;
            if (pa) begin
                obsData.push_back(24'(aData)); obsPhase.push_back(aPhase); obsIndex.push_back(aIndex);
            end
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic collectB(input int n, input int readyPct);
        int cyc = 0;
        logic pv = 1'b0, pa = 1'b0;
        logic [23:0] pd = '0;
        logic [1:0] pp = '0;
        logic [31:0] pi = '0;
        while (obsData.size() < n && cyc < 40 * n + 100) begin
            if (pv && !pa && (!bValid || bData !== pd || bPhase !== pp || bIndex !== pi)) holdBad++;
            bReady = ($urandom_range(99, 0) < readyPct);
            pv = bValid; pa = bValid & bReady; pd = bData; pp = bPhase; pi = bIndex;
            if (pa) begin
                obsData.push_back(bData); obsPhase.push_back(bPhase); obsIndex.push_back(bIndex);
            end
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic pulseStartA();
        @(negedge clock); aStart = 1'b1;
        @(negedge clock); aStart = 1'b0;
    endtask

    task automatic pulseStartB();
        @(negedge clock); bStart = 1'b1;
        @(negedge clock); bStart = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset_n = 1'b0; aStart = 1'b0; aLoad = 1'b0; bStart = 1'b0; bLoad = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        total++;
        if ({aValid, aData, aPhase, aIndex, aBusy, aDone} !== '0) $display("FAIL reset_a outputs got %h want 0", {aValid, aData, aPhase, aIndex, aBusy, aDone});
        else passed++;
        total++;
        if ({bValid, bData, bPhase, bIndex, bBusy, bDone} !== '0) $display("FAIL reset_b outputs got %h want 0", {bValid, bData, bPhase, bIndex, bBusy, bDone});
        else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_default_run();
        modelSeed(SEED);
        buildExp(1, 4, A_COUNT);
        clearObs();
        pulseStartA();
        total++;
        if ({aValid, aBusy, aPhase} !== 4'b1100) $display("FAIL first_beat_latency valid/busy/phase got %b want 1100", {aValid, aBusy, aPhase});
        else passed++;
        collectA(A_COUNT + 2, 100);
        total++;
        if (obsData.size() != A_COUNT + 2) $display("FAIL run1_beats got %0d want %0d", obsData.size(), A_COUNT + 2);
        else passed++;
        for (int i = 0; i < obsData.size(); i++) begin
            total++;
            if (obsData[i] !== expData[i] || obsPhase[i] !== expPhase[i] || obsIndex[i] !== expIndex[i])
                $display("FAIL run1 beat %0d got data %h phase %0d index %0d want data %h phase %0d index %0d",
                         i, obsData[i], obsPhase[i], obsIndex[i], expData[i], expPhase[i], expIndex[i]);
            else passed++;
        end
        total++;
        if ({aDone, aValid, aBusy} !== 3'b100) $display("FAIL run1_done done/valid/busy got %b want 100", {aDone, aValid, aBusy});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] snapD;
        logic [31:0] snapI;
        buildExp(1, 4, A_COUNT);
        clearObs();
        pulseStartA();
        collectA(50, 60);
        aReady = 1'b0;
        aStart = 1'b1;
        snapD = aData;
        snapI = aIndex;
        repeat (5) begin
            @(negedge clock);
            total++;
            if (aValid !== 1'b1 || aData !== snapD || aIndex !== snapI)
                $display("FAIL stall_hold got valid %b data %h index %0d want valid 1 data %h index %0d", aValid, aData, aIndex, snapD, snapI);
            else passed++;
        end
        aStart = 1'b0;
        collectA(A_COUNT + 2, 70);
        total++;
        if (obsData.size() < 52 || obsIndex[51] !== snapI + 32'd1)
            $display("FAIL stall_advance index got %0d want %0d", (obsData.size() < 52) ? 32'hFFFFFFFF : obsIndex[51], snapI + 32'd1);
        else passed++;
        total++;
        if (obsData.size() != A_COUNT + 2) $display("FAIL run2_beats got %0d want %0d", obsData.size(), A_COUNT + 2);
        else passed++;
        for (int i = 0; i < obsData.size(); i++) begin
            total++;
            if (obsData[i] !== expData[i] || obsPhase[i] !== expPhase[i] || obsIndex[i] !== expIndex[i])
                $display("FAIL run2 beat %0d got data %h phase %0d index %0d want data %h phase %0d index %0d",
                         i, obsData[i], obsPhase[i], obsIndex[i], expData[i], expPhase[i], expIndex[i]);
            else passed++;
        end
        total++;
        if (holdBad != 0) $display("FAIL run2_hold unstable stall cycles got %0d want 0", holdBad);
        else passed++;
        total++;
        if (aDone !== 1'b1) $display("FAIL run2_done got %b want 1", aDone);
        else passed++;
    endtask

    task automatic test_reset_midrun();
        modelSeed(SEED);
        buildExp(1, 4, A_COUNT);
        clearObs();
        pulseStartA();
        collectA(9, 100);
        aReady = 1'b0;
        total++;
        if (aIndex !== 32'd7 || aPhase !== 2'd2) $display("FAIL midrun_position got index %0d phase %0d want 7 2", aIndex, aPhase);
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({aValid, aData, aPhase, aIndex, aBusy, aDone} !== '0) $display("FAIL async_reset outputs got %h want 0", {aValid, aData, aPhase, aIndex, aBusy, aDone});
        else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        aReady = 1'b1;
        repeat (3) begin
            @(negedge clock);
            total++;
            if ({aValid, aBusy, aDone} !== 3'b000) $display("FAIL post_reset_idle valid/busy/done got %b want 000", {aValid, aBusy, aDone});
            else passed++;
        end
        clearObs();
        pulseStartA();
        collectA(12, 100);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (i >= obsData.size() || obsData[i] !== expData[i] || obsPhase[i] !== expPhase[i] || obsIndex[i] !== expIndex[i])
                $display("FAIL replay beat %0d got data %h want data %h", i, (i < obsData.size()) ? obsData[i] : 24'hFFFFFF, expData[i]);
            else passed++;
        end
    endtask

    task automatic test_seed_load();
        doReset();
        modelSeed(SEED);
        buildExp(1, 4, A_COUNT);
        clearObs();
`ifdef XORSHIFT_STIM_SEED_LOAD_EN
        aSeed = SEED;
`else
        aSeed = 32'd0;
`endif
        @(negedge clock); aLoad = 1'b1;
        @(negedge clock); aStart = 1'b1;
        @(negedge clock); aStart = 1'b0; aLoad = 1'b0;
        collectA(20, 80);
        aSeed = $urandom;
        aLoad = 1'b1;
        collectA(40, 80);
        aLoad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            total++;
            if (i >= obsData.size() || obsData[i] !== expData[i] || obsPhase[i] !== expPhase[i] || obsIndex[i] !== expIndex[i])
                $display("FAIL seed_load beat %0d got data %h want data %h", i, (i < obsData.size()) ? obsData[i] : 24'hFFFFFF, expData[i]);
            else passed++;
        end
    endtask

    task automatic test_multilane();
        doReset();
        modelSeed(SEED);
        for (int run = 0; run < 2; run++) begin
            buildExp(B_CH, B_W, B_COUNT);
            clearObs();
            pulseStartB();
            collectB(B_COUNT + 2, 50 + 20 * run);
            total++;
            if (obsData.size() != B_COUNT + 2) $display("FAIL lanes_beats run %0d got %0d want %0d", run, obsData.size(), B_COUNT + 2);
            else passed++;
            for (int i = 0; i < obsData.size(); i++) begin
                total++;
                if (obsData[i] !== expData[i] || obsPhase[i] !== expPhase[i] || obsIndex[i] !== expIndex[i])
                    $display("FAIL lanes run %0d beat %0d got data %h phase %0d index %0d want data %h phase %0d index %0d",
                             run, i, obsData[i], obsPhase[i], obsIndex[i], expData[i], expPhase[i], expIndex[i]);
                else passed++;
            end
            total++;
            if ({bDone, bValid, bBusy} !== 3'b100 || holdBad != 0)
                $display("FAIL lanes_done run %0d done/valid/busy got %b holds %0d want 100 holds 0", run, {bDone, bValid, bBusy}, holdBad);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_back_to_back();
        test_reset_midrun();
        test_seed_load();
        test_multilane();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
